// File: rtl/channel_mixer.sv
// Time-multiplexed mixer: one channel MAC per clock, per-channel gain, saturating output.
// A SampleTick snapshots all channel waveforms; the result appears NUM_CHANNELS+1 edges later.
module channel_mixer #(
   parameter int unsigned WAVE_DEPTH   = 8,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned GAIN_DEPTH   = 8,
   localparam int unsigned AddrW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                               Clock,
   input  logic                               Reset,
   input  logic [NUM_CHANNELS*WAVE_DEPTH-1:0] Waveforms,
   input  logic                               SampleTick,
   input  logic                               GainWr,
   input  logic [AddrW-1:0]                   GainAddr,
   input  logic [GAIN_DEPTH-1:0]              GainData,
   output logic [WAVE_DEPTH-1:0]              MixOut,
   output logic                               MixValid,
   output logic                               Busy,
   output logic                               Saturated,
   output logic                               Overrun
);

   localparam int unsigned AccW = WAVE_DEPTH + GAIN_DEPTH + 1 + $clog2(NUM_CHANNELS);
   localparam logic [WAVE_DEPTH-1:0] Mid = WAVE_DEPTH'(1) << (WAVE_DEPTH - 1);
   localparam logic signed [AccW-1:0] SMax = AccW'((2 ** (WAVE_DEPTH - 1)) - 1);
   localparam logic signed [AccW-1:0] SMin = ~SMax;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e                  state_q, state_d;
   logic [WAVE_DEPTH-1:0]   snap_q [NUM_CHANNELS];
   logic [GAIN_DEPTH-1:0]   gain_q [NUM_CHANNELS];
   logic signed [AccW-1:0]  acc_q;
   logic [AddrW-1:0]        idx_q;

   logic signed [AccW-1:0]  centred, gain_s, product, shifted, clamped;
   logic                    last_idx, clamp_hit;

   // Datapath works at accumulator width; the true product never exceeds it.
   always_comb begin
      centred   = $signed(AccW'(snap_q[idx_q])) - $signed(AccW'(Mid));
      gain_s    = $signed(AccW'(gain_q[idx_q]));
      product   = centred * gain_s;
      shifted   = acc_q >>> GAIN_DEPTH;
      clamped   = shifted;
      clamp_hit = 1'b0;
      if (shifted > SMax) begin
         clamped   = SMax;
         clamp_hit = 1'b1;
      end else if (shifted < SMin) begin
         clamped   = SMin;
         clamp_hit = 1'b1;
      end
      last_idx = (idx_q == AddrW'(NUM_CHANNELS - 1));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (SampleTick) state_d = StAccum;
         StAccum: if (last_idx) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            snap_q[i] <= '0;
            gain_q[i] <= '0;
         end
         acc_q     <= '0;
         idx_q     <= '0;
         MixOut    <= Mid;
         MixValid  <= 1'b0;
         Saturated <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         MixValid <= 1'b0;
         if (GainWr && (32'(GainAddr) < NUM_CHANNELS)) gain_q[GainAddr] <= GainData;
         if (SampleTick && (state_q != StIdle)) Overrun <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (SampleTick) begin
                  for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                     snap_q[i] <= Waveforms[i*WAVE_DEPTH +: WAVE_DEPTH];
                  end
                  acc_q <= '0;
                  idx_q <= '0;
               end
            end
            StAccum: begin
               acc_q <= acc_q + product;
               if (!last_idx) idx_q <= idx_q + AddrW'(1);
            end
            StDone: begin
               // Adding the midpoint to a value in [-Mid, Mid-1] is an MSB flip.
               MixOut    <= clamped[WAVE_DEPTH-1:0] ^ Mid;
               Saturated <= clamp_hit;
               MixValid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Busy = (state_q != StIdle);

endmodule

// File: tb/tb_channel_mixer.sv
// Directed bench for channel_mixer (W=8, G=8, N=4) with hand-computed expectations.
module tb_channel_mixer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] Waveforms;
   logic        SampleTick;
   logic        GainWr;
   logic [1:0]  GainAddr;
   logic [7:0]  GainData;
   logic [7:0]  MixOut;
   logic        MixValid;
   logic        Busy;
   logic        Saturated;
   logic        Overrun;

   int passed = 0;
   int total  = 0;

   channel_mixer #(
      .WAVE_DEPTH   (8),
      .NUM_CHANNELS (4),
      .GAIN_DEPTH   (8)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Waveforms  (Waveforms),
      .SampleTick (SampleTick),
      .GainWr     (GainWr),
      .GainAddr   (GainAddr),
      .GainData   (GainData),
      .MixOut     (MixOut),
      .MixValid   (MixValid),
      .Busy       (Busy),
      .Saturated  (Saturated),
      .Overrun    (Overrun)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic set_gain(input logic [1:0] addr, input logic [7:0] data);
      GainWr   = 1'b1;
      GainAddr = addr;
      GainData = data;
      step();
      GainWr   = 1'b0;
   endtask

   task automatic set_all_gains(input logic [7:0] data);
      for (int i = 0; i < 4; i++) set_gain(2'(i), data);
   endtask

   // Tick with wav, then present wav_after for the rest of the mix.
   task automatic run_mix(input string tag, input logic [31:0] wav, input logic [31:0] wav_after,
                          input logic [7:0] exp_out, input logic exp_sat);
      int n;
      Waveforms  = wav;
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      Waveforms  = wav_after;
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      n = 0;
      while (!MixValid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd5);
      check({tag, "_out"}, 32'(MixOut), 32'(exp_out));
      check({tag, "_sat"}, 32'(Saturated), 32'(exp_sat));
      step();
      check({tag, "_valid_drop"}, 32'(MixValid), 32'd0);
   endtask

   initial begin
      int pulses;
      Reset      = 1'b1;
      Waveforms  = '0;
      SampleTick = 1'b0;
      GainWr     = 1'b0;
      GainAddr   = '0;
      GainData   = '0;
      #2;
      check("rst_out", 32'(MixOut), 32'd128);
      check("rst_valid", 32'(MixValid), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_sat", 32'(Saturated), 32'd0);
      check("rst_ovr", 32'(Overrun), 32'd0);
      step();
      step();
      Reset = 1'b0;
      step();

      set_gain(2'd0, 8'd128);
      run_mix("g128", 32'h0000_00FF, 32'h0000_00FF, 8'd191, 1'b0);

      set_all_gains(8'd255);
      run_mix("hi_clamp", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd255, 1'b1);
      run_mix("lo_clamp", 32'h0000_0000, 32'h0000_0000, 8'd0, 1'b1);
      run_mix("mid", 32'h8080_8080, 32'h8080_8080, 8'd128, 1'b0);
      // Snapshot taken at the tick; later waveform changes must not leak in.
      run_mix("snap", 32'h8080_8080, 32'hFFFF_FFFF, 8'd128, 1'b0);
      // Centred 72,-28,22,-68 -> -2*255 = -510, arithmetic shift floors to -2.
      run_mix("floor", 32'h3C96_64C8, 32'h3C96_64C8, 8'd126, 1'b0);

      // Asynchronous reset mid-accumulation.
      Waveforms  = 32'hFFFF_FFFF;
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      step();
      Reset = 1'b1;
      #1;
      check("amid_out", 32'(MixOut), 32'd128);
      check("amid_busy", 32'(Busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (MixValid) pulses++;
      end
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (MixValid) pulses++;
      end
      check("amid_no_valid", 32'(pulses), 32'd0);
      run_mix("post_rst_g0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd128, 1'b0);
      set_gain(2'd0, 8'd128);
      run_mix("post_rst_g128", 32'h0000_00FF, 32'h0000_00FF, 8'd191, 1'b0);

      // Tick presented for the DONE edge is an overrun and is dropped.
      check("ovr_clear", 32'(Overrun), 32'd0);
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      for (int i = 0; i < 4; i++) step();
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      check("done_tick_valid", 32'(MixValid), 32'd1);
      check("done_tick_out", 32'(MixOut), 32'd191);
      check("done_tick_ovr", 32'(Overrun), 32'd1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (MixValid) pulses++;
      end
      check("done_tick_pulses", 32'(pulses), 32'd0);

      // Second tick two clocks after the first: ignored, one pulse only.
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      check("ovr_rst", 32'(Overrun), 32'd0);
      set_gain(2'd1, 8'd64);
      Waveforms  = 32'h0000_0000;
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      step();
      SampleTick = 1'b1;
      step();
      SampleTick = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (MixValid) pulses++;
      end
      check("ovr2_pulses", 32'(pulses), 32'd1);
      check("ovr2_flag", 32'(Overrun), 32'd1);
      // Channel 1 at 0 with gain 64: -128*64 >>> 8 = -32 -> 96.
      check("ovr2_out", 32'(MixOut), 32'd96);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
